mode_counter: RTL and testbench
===============================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 8: count register width in bits.
REQ-002 Parameter MIN_COUNT, default 0: lower bound of the count range.
REQ-003 Parameter MAX_COUNT, default 2**WIDTH-1: upper bound of the count range.
REQ-004 Parameter STEP, default 1: increment/decrement per enabled cycle.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 en  in  1: count enable; a step occurs only in RUN with en=1.
REQ-008 start  in  1: enter RUN; dir and mode are sampled on this cycle.
REQ-009 stop  in  1: return to IDLE, holding count.
REQ-010 dir  in  1: direction, 1=up, 0=down.
REQ-011 mode  in  2: cnt_mode_e, one of WRAP, SAT or ONESHOT.
REQ-012 load  in  1: synchronous load request.
REQ-013 load_val  in  WIDTH: load value.
REQ-014 count  out  WIDTH: current count, registered.
REQ-015 tc  out  1: registered one-cycle terminal-event pulse.
REQ-016 busy  out  1: high in RUN.
REQ-017 done  out  1: high in DONE.

Function
REQ-018 FSM states: IDLE, RUN, DONE; per-cycle priority is rst > load > stop > start > step.
REQ-019 load (any state): count = load_val clamped to [MIN_COUNT, MAX_COUNT]; state goes to IDLE; tc=0.
REQ-020 stop: RUN or DONE go to IDLE; count holds.
REQ-021 start from IDLE: go to RUN, count unchanged.
REQ-022 start from DONE: go to RUN, count reloaded to MIN_COUNT (dir=1) or MAX_COUNT (dir=0).
REQ-023 start while in RUN: re-samples dir and mode; count unchanged.
REQ-024 dir and mode are registered at start; changes during RUN have no effect.
REQ-025 Step arithmetic uses WIDTH+1 bits; a terminal event is a step where count+STEP>MAX_COUNT (up) or count-STEP<MIN_COUNT (down).
REQ-026 Non-terminal step: count = count±STEP.
REQ-027 Terminal event in WRAP: count goes to MIN_COUNT (up) or MAX_COUNT (down); stay in RUN.
REQ-028 Terminal event in SAT: count clamps to MAX_COUNT (up) or MIN_COUNT (down); stay in RUN; the event repeats on every further enabled cycle.
REQ-029 Terminal event in ONESHOT: count clamps as in SAT; state goes to DONE.
REQ-030 tc is high on the cycle after each terminal event and low otherwise.
REQ-031 en=0 in RUN: count, state and tc=0 hold/deassert.
REQ-032 Reserved mode 2'b11 behaves as WRAP.

Reset
REQ-033 rst=1 at a clock edge: count=MIN_COUNT, state=IDLE, tc=0, busy=0, done=0, sampled dir=1, sampled mode=WRAP; this applies mid-RUN too.
REQ-034 With rst=1, all inputs other than clk are ignored.

Configuration
REQ-035 Macro MODE_COUNTER_EVT_CNT_EN defined: adds output evt_cnt [7:0], reset to 0, incremented on each terminal event, saturating at 8'hFF, cleared by load.
REQ-036 Macro undefined: evt_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Package counter_pkg holds:
- typedef enum logic[1:0] cnt_mode_e: CNT_WRAP=00, CNT_SAT=01, CNT_ONESHOT=10.
- typedef enum cnt_state_e: IDLE, RUN, DONE.
- localparam EVT_W=8.
REQ-038 Combinational sub-module count_step computes the next value and the terminal flag from count, dir, mode and the parameters.
REQ-039 Elaboration checks raise $error unless:
- MIN_COUNT < MAX_COUNT <= 2**WIDTH-1
- 1 <= STEP <= MAX_COUNT-MIN_COUNT

Verification (WIDTH=4, MIN_COUNT=2, MAX_COUNT=9, STEP=1 unless stated)
REQ-040 WRAP up: reset, start dir=1, 8 enabled cycles -> count 2..9 then 2; single tc pulse after the 8th step.
REQ-041 SAT down: load 4, start dir=0 mode=SAT, 4 enabled cycles -> count 3,2,2,2; tc high on cycles 3 and 4; busy stays 1.
REQ-042 ONESHOT, STEP=3: start up from 2 -> count 5,8,9; done=1, busy=0, tc pulse; next start reloads count to 2.
REQ-043 Reset mid-run: RUN at count 6, rst pulse -> count=2, IDLE, tc=busy=done=0 on the next cycle.
REQ-044 load, start and stop together with load_val=15 -> count=9, IDLE; with en=0 in RUN, count holds.
REQ-045 Macro on: 3 wraps then load -> evt_cnt 1,2,3 then 0; 300 SAT terminal events -> evt_cnt=255.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the mode_counter block.
// Mode and state encodings plus the event counter width.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10
    } cnt_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cnt_state_e;

    localparam int EVT_W = 8;

endpackage

// File: rtl/count_step.sv
// Next-count and terminal-event logic for one enabled step.
// Arithmetic is done one bit wider than the count.
module count_step
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MIN_COUNT = 0,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int STEP      = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next,
    output logic             term
);

    localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_COUNT);
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] LOW_W  = (WIDTH+1)'(MIN_COUNT + STEP);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH:0] ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           clamp;

    // Wide add/sub; down-terminal compare avoids underflow wrap.
    always_comb begin
        ext   = {1'b0, count};
        sum   = ext + STEP_W;
        diff  = ext - STEP_W;
        clamp = (mode == CNT_SAT) || (mode == CNT_ONESHOT);
        if (dir) begin
            term = (sum > MAX_W);
            if (!term) next = sum[WIDTH-1:0];
            else       next = clamp ? MAX_V : MIN_V;
        end else begin
            term = (ext < LOW_W) || (diff < MIN_W);
            if (!term) next = diff[WIDTH-1:0];
            else       next = clamp ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mode_counter.sv
// Bounded up/down counter with WRAP, SAT and ONESHOT modes.
// Define MODE_COUNTER_EVT_CNT_EN to add the evt_cnt output.
module mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MIN_COUNT = 0,
    parameter int MAX_COUNT = 2**WIDTH-1,
    parameter int STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
`ifdef MODE_COUNTER_EVT_CNT_EN
    output logic             done,
    output logic [EVT_W-1:0] evt_cnt
`else
    output logic             done
`endif
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    if (!(MIN_COUNT < MAX_COUNT && MAX_COUNT <= 2**WIDTH-1))
    begin : g_bad_range
        $error("mode_counter: bad MIN_COUNT/MAX_COUNT");
    end

    if (!(STEP >= 1 && STEP <= MAX_COUNT - MIN_COUNT))
    begin : g_bad_step
        $error("mode_counter: bad STEP");
    end

    cnt_state_e       state;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] step_next;
    logic             step_term;
    logic [WIDTH-1:0] load_clamped;
    logic             step_fire;

    count_step #(
        .WIDTH    (WIDTH),
        .MIN_COUNT(MIN_COUNT),
        .MAX_COUNT(MAX_COUNT),
        .STEP     (STEP)
    ) u_step (
        .count(count),
        .dir  (dir_q),
        .mode (mode_q),
        .next (step_next),
        .term (step_term)
    );

    // Clamp the load value into the legal count range.
    always_comb begin
        load_clamped = load_val;
        if (load_val < MIN_V) load_clamped = MIN_V;
        if (load_val > MAX_V) load_clamped = MAX_V;
    end

    assign step_fire = !load && !stop && !start && en && (state == RUN);

    // Control FSM: rst > load > stop > start > step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= MIN_V;
            tc     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dir_q  <= 1'b1;
            mode_q <= CNT_WRAP;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count <= load_clamped;
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start) begin
                state  <= RUN;
                busy   <= 1'b1;
                done   <= 1'b0;
                dir_q  <= dir;
                mode_q <= mode;
                if (state == DONE) count <= dir ? MIN_V : MAX_V;
            end else if (step_fire) begin
                count <= step_next;
                tc    <= step_term;
                if (step_term && mode_q == CNT_ONESHOT) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

`ifdef MODE_COUNTER_EVT_CNT_EN
    // Saturating count of terminal events, cleared by load.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (load) begin
            evt_cnt <= '0;
        end else if (step_fire && step_term && evt_cnt != '1) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: two instances (STEP 1 and 3)
// share stimulus; a spec-level model feeds per-cycle expectations.
module tb_mode_counter;

    localparam int IDLE_S = 0;
    localparam int RUN_S  = 1;
    localparam int DONE_S = 2;

    typedef struct {
        int count;
        int st;
        int dir;
        int mode;
        int tc;
        int evt;
    } mdl_t;

    typedef struct {
        int count;
        int tc;
        int busy;
        int done;
        int evt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] a_count, b_count;
    logic       a_tc, a_busy, a_done;
    logic       b_tc, b_busy, b_done;
`ifdef MODE_COUNTER_EVT_CNT_EN
    logic [7:0] a_evt, b_evt;
`endif

    int checks = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];
    mdl_t ma, mb;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(4), .MIN_COUNT(2), .MAX_COUNT(9), .STEP(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .dir(dir), .mode(mode), .load(load), .load_val(load_val),
        .count(a_count), .tc(a_tc), .busy(a_busy),
`ifdef MODE_COUNTER_EVT_CNT_EN
        .done(a_done), .evt_cnt(a_evt)
`else
        .done(a_done)
`endif
    );

    mode_counter #(.WIDTH(4), .MIN_COUNT(2), .MAX_COUNT(9), .STEP(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .dir(dir), .mode(mode), .load(load), .load_val(load_val),
        .count(b_count), .tc(b_tc), .busy(b_busy),
`ifdef MODE_COUNTER_EVT_CNT_EN
        .done(b_done), .evt_cnt(b_evt)
`else
        .done(b_done)
`endif
    );

    function automatic mdl_t mstep(mdl_t s, int mn, int mx, int stp);
        mdl_t n = s;
        int t;
        n.tc = 0;
        if (rst) begin
            n.count = mn; n.st = IDLE_S; n.dir = 1;
            n.mode = 0; n.evt = 0;
        end else if (load) begin
            t = int'(load_val);
            n.count = (t < mn) ? mn : ((t > mx) ? mx : t);
            n.st = IDLE_S; n.evt = 0;
        end else if (stop) begin
            n.st = IDLE_S;
        end else if (start) begin
            if (s.st == DONE_S) n.count = dir ? mn : mx;
            n.st = RUN_S; n.dir = int'(dir); n.mode = int'(mode);
        end else if (s.st == RUN_S && en) begin
            t = (s.dir != 0) ? s.count + stp : s.count - stp;
            if (t > mx || t < mn) begin
                n.tc = 1;
                if (s.evt < 255) n.evt = s.evt + 1;
                if (s.mode == 1 || s.mode == 2) begin
                    n.count = (s.dir != 0) ? mx : mn;
                    if (s.mode == 2) n.st = DONE_S;
                end else begin
                    n.count = (s.dir != 0) ? mn : mx;
                end
            end else begin
                n.count = t;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(mdl_t s);
        exp_t e;
        e.count = s.count;
        e.tc = s.tc;
        e.busy = (s.st == RUN_S) ? 1 : 0;
        e.done = (s.st == DONE_S) ? 1 : 0;
        e.evt = s.evt;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic sp,
                       input logic st, input logic e, input logic d,
                       input logic [1:0] m, input logic [3:0] lv);
        @(negedge clk);
        rst = r; load = l; stop = sp; start = st;
        en = e; dir = d; mode = m; load_val = lv;
        ma = mstep(ma, 2, 9, 1);
        mb = mstep(mb, 2, 9, 3);
        qa.push_back(to_exp(ma));
        qb.push_back(to_exp(mb));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_count", int'(a_count), e.count);
                chk("a_tc", int'(a_tc), e.tc);
                chk("a_busy", int'(a_busy), e.busy);
                chk("a_done", int'(a_done), e.done);
`ifdef MODE_COUNTER_EVT_CNT_EN
                chk("a_evt", int'(a_evt), e.evt);
`endif
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_count", int'(b_count), e.count);
                chk("b_tc", int'(b_tc), e.tc);
                chk("b_busy", int'(b_busy), e.busy);
                chk("b_done", int'(b_done), e.done);
`ifdef MODE_COUNTER_EVT_CNT_EN
                chk("b_evt", int'(b_evt), e.evt);
`endif
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '{count: 0, st: 0, dir: 1, mode: 0, tc: 0, evt: 0};
        mb = ma;

        // Reset state
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("rst_count", int'(a_count), 2);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_done", int'(a_done), 0);

        // WRAP up: 8 steps end on 2 with a tc pulse
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 1, 0, 0);
        settle();
        chk("wrap_count", int'(a_count), 2);
        chk("wrap_tc", int'(a_tc), 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("hold_tc", int'(a_tc), 0);

        // SAT down from 4: 3,2,2,2
        cyc(0, 1, 0, 0, 0, 0, 0, 4);
        cyc(0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("sat_count", int'(a_count), 2);
        chk("sat_tc", int'(a_tc), 1);
        chk("sat_busy", int'(a_busy), 1);

        // ONESHOT STEP=3 on dut_b: 5,8,9 then DONE
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("os_count", int'(b_count), 9);
        chk("os_done", int'(b_done), 1);
        chk("os_busy", int'(b_busy), 0);
        chk("os_tc", int'(b_tc), 1);
        cyc(0, 0, 0, 1, 0, 1, 2, 0);
        settle();
        chk("os_reload", int'(b_count), 2);

        // Reset in the middle of a run at count 6
        cyc(0, 1, 0, 0, 0, 1, 0, 6);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 1, 0, 0);
        settle();
        chk("mid_rst_count", int'(a_count), 2);
        chk("mid_rst_busy", int'(a_busy), 0);

        // load+start+stop together, then hold with en=0
        cyc(0, 1, 1, 1, 1, 1, 0, 15);
        settle();
        chk("ld_clamp", int'(a_count), 9);
        chk("ld_idle", int'(a_busy), 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("en0_hold", int'(a_count), 9);

        // Long SAT run: event counter saturates
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 310; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        settle();
`ifdef MODE_COUNTER_EVT_CNT_EN
        chk("evt_sat", int'(a_evt), 255);
`endif
        chk("sat_long", int'(a_count), 9);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(99) < 2),
                ($urandom_range(99) < 5),
                ($urandom_range(99) < 5),
                ($urandom_range(99) < 10),
                ($urandom_range(99) < 75),
                1'($urandom_range(1)),
                2'($urandom_range(3)),
                4'($urandom_range(15)));
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
